// File: rtl/tlp_pkg.sv
// Shared definitions for the TLP class scheduler: default word width,
// traffic class codes, the link INIT state code and FSM state encodings.
package tlp_pkg;

  localparam int DATA_W_DEF = 12;

  typedef enum logic [1:0] {
    CLASS0 = 2'd0,
    CLASS1 = 2'd1,
    CLASS2 = 2'd2,
    CLASS3 = 2'd3
  } tlp_class_t;

  localparam logic [3:0] LINK_INIT = 4'b0001;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/tlp_credit_counter.sv
// Per-class 4-bit credit counter. Loads MAX_CREDITS on reset or init,
// saturates on return, and a simultaneous return and spend cancel out.
module tlp_credit_counter #(
  parameter int MAX_CREDITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic       init,
  output logic [3:0] count,
  output logic       nonzero
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_CREDITS);

  // Credit count update; returns beyond MAX_CNT are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= MAX_CNT;
    end else if (init) begin
      count <= MAX_CNT;
    end else if (inc && !dec) begin
      if (count != MAX_CNT) count <= count + 4'd1;
    end else if (dec && !inc) begin
      count <= count - 4'd1;
    end
  end

  assign nonzero = (count != 4'd0);

endmodule

// File: rtl/tlp_class_scheduler.sv
// Round-robin scheduler across four TLP traffic classes with a one-word
// output register. Optional credit gating is enabled by defining
// TLP_SCHED_CREDIT_EN; without it every valid class is eligible.
module tlp_class_scheduler
  import tlp_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_CREDITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        states,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  input  logic [DATA_W-1:0] req_data3,
  input  logic [3:0]        req_valid,
  output logic [3:0]        req_ready,
  input  logic [3:0]        credit_ret,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        grant_id
);

  sched_state_t      state, state_next;
  logic [1:0]        rr_ptr;
  logic [3:0]        elig;
  logic              flush, load, accept, found;
  logic [1:0]        pick, idx;
  logic [DATA_W-1:0] pick_data;

  assign flush = (states == LINK_INIT);
  assign load  = (!out_valid || out_ready) && !flush;

`ifdef TLP_SCHED_CREDIT_EN
  logic [3:0] has_credit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_credit
    logic [3:0] unused_count;
    tlp_credit_counter #(.MAX_CREDITS(MAX_CREDITS)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (credit_ret[gi]),
      .dec     (req_ready[gi]),
      .init    (flush),
      .count   (unused_count),
      .nonzero (has_credit[gi])
    );
  end

  assign elig = req_valid & has_credit;
`else
  logic unused_credit_ret;
  assign unused_credit_ret = ^credit_ret;
  assign elig = req_valid;
`endif

  // Search classes rr_ptr+1 .. rr_ptr+4 and take the first eligible one.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    idx   = rr_ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign accept    = load && found;
  assign req_ready = accept ? onehot4(pick) : 4'b0000;

  // Select the word offered by the picked class.
  always_comb begin
    pick_data = req_data0;
    case (pick)
      2'd1:    pick_data = req_data1;
      2'd2:    pick_data = req_data2;
      2'd3:    pick_data = req_data3;
      default: pick_data = req_data0;
    endcase
  end

  // Output FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: BUSY while a word is held, IDLE once drained with nothing new.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = BUSY;
        BUSY:    if (out_ready && !accept) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign out_valid = (state == BUSY);

  // Output word register and round-robin pointer; data holds when not loading.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      grant_id <= 2'd0;
      rr_ptr   <= 2'd3;
    end else if (flush) begin
      rr_ptr   <= 2'd3;
    end else if (accept) begin
      out_data <= pick_data;
      grant_id <= pick;
      rr_ptr   <= pick;
    end
  end

endmodule

// File: tb/tb_tlp_class_scheduler.sv
// Directed bench for tlp_class_scheduler; expectations adapt to whether
// TLP_SCHED_CREDIT_EN is defined for the build.
module tb_tlp_class_scheduler;

`ifdef TLP_SCHED_CREDIT_EN
  localparam bit CR = 1'b1;
`else
  localparam bit CR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  states;
  logic [11:0] d [4];
  logic [3:0]  req_valid, req_ready, credit_ret;
  logic [11:0] out_data;
  logic        out_valid, out_ready;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;
  int n, nb, nc;

  always #5 clk = ~clk;

  tlp_class_scheduler #(.DATA_W(12), .MAX_CREDITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .states     (states),
    .req_data0  (d[0]),
    .req_data1  (d[1]),
    .req_data2  (d[2]),
    .req_data3  (d[3]),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .credit_ret (credit_ret),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .grant_id   (grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    d[0] = 12'h0A1; d[1] = 12'h4B2; d[2] = 12'h8C3; d[3] = 12'hCD4;
    reset = 1'b1; states = 4'b0010; req_valid = 4'b0000;
    credit_ret = 4'b0000; out_ready = 1'b0;

    // Reset values before any clock edge
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_grant_id",  32'(grant_id),  32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // All classes valid: grants 0,1,2,3,0
    #10;
    reset = 1'b0; req_valid = 4'b1111; out_ready = 1'b1;
    #1;
    chk("rr_first_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc;
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_grant", 32'(grant_id), 32'(i % 4));
      chk("rr_data",  32'(out_data), 32'(d[i % 4]));
      chk("rr_next_ready", 32'(req_ready), 32'(4'b0001 << ((i + 1) % 4)));
    end

    // Stall: output held, nothing accepted
    out_ready = 1'b0;
    #1;
    chk("stall_ready0", 32'(req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_grant", 32'(grant_id), 32'd0);
      chk("stall_data",  32'(out_data), 32'(d[0]));
      chk("stall_ready", 32'(req_ready), 32'd0);
    end

    // Drain with nothing eligible: valid drops, data held
    out_ready = 1'b1; req_valid = 4'b0000;
    #1;
    chk("drain_ready", 32'(req_ready), 32'd0);
    cyc;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_grant", 32'(grant_id), 32'd0);
    chk("drain_data",  32'(out_data), 32'(d[0]));

    // INIT flush mid-stream with a credit return on class 0
    req_valid = 4'b1111;
    #1;
    chk("resume_ready", 32'(req_ready), 32'b0010);
    cyc;
    chk("resume_grant1", 32'(grant_id), 32'd1);
    cyc;
    chk("resume_grant2", 32'(grant_id), 32'd2);
    states = 4'b0001; credit_ret = 4'b0001;
    #1;
    chk("flush_ready", 32'(req_ready), 32'd0);
    cyc;
    chk("flush_valid", 32'(out_valid), 32'd0);
    states = 4'b0010; credit_ret = 4'b0000;
    #1;
    chk("flush_next_ready", 32'(req_ready), 32'b0001);
    req_valid = 4'b0100;

    // Only class 2 valid: credit-limited word count
    n = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req_ready == 4'b0100) n++;
      cyc;
    end
    chk("class2_words", 32'(n), CR ? 32'd8 : 32'd12);
    chk("class2_valid_end", 32'(out_valid), CR ? 32'd0 : 32'd1);
    #1;
    chk("class2_ready_end", 32'(req_ready), CR ? 32'd0 : 32'b0100);

    // Single credit return on an exhausted class
    credit_ret = 4'b0100;
    #1;
    chk("ret_ready_same", 32'(req_ready), CR ? 32'd0 : 32'b0100);
    cyc;
    credit_ret = 4'b0000;
    #1;
    chk("ret_ready_next", 32'(req_ready), 32'b0100);
    cyc;
    chk("ret_grant", 32'(grant_id), 32'd2);
    chk("ret_valid", 32'(out_valid), 32'd1);
    #1;
    chk("ret_ready_after", 32'(req_ready), CR ? 32'd0 : 32'b0100);

    // Saturation at max and accept+return cancellation on class 1
    states = 4'b0001; req_valid = 4'b0000;
    cyc;
    states = 4'b0010; credit_ret = 4'b0010;
    cyc;
    cyc;
    req_valid = 4'b0010;
    nb = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (req_ready == 4'b0010) nb++;
      cyc;
    end
    credit_ret = 4'b0000;
    nc = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (req_ready == 4'b0010) nc++;
      cyc;
    end
    chk("cancel_words", 32'(nb), 32'd3);
    chk("sat_words", 32'(nc), CR ? 32'd8 : 32'd10);

    // Reset mid-transfer discards the held word
    out_ready = 1'b1; req_valid = 4'b0001;
    #1;
    cyc;
    out_ready = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_grant", 32'(grant_id), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data",  32'(out_data), 32'd0);
    #3;
    reset = 1'b0; req_valid = 4'b0000;
    cyc;
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
